ffe_coeff_manager: RTL and testbench

- Double-buffered tap-coefficient store and update sequencer for the 4-tap FFE MAC datapath.
- The host writes new taps into a shadow bank through a valid/ready port, then requests a commit.
- The block swaps shadow and active banks only at an FFE symbol boundary, or immediately if the FFE is idle.
- It then re-syncs the shadow bank so later partial updates stay coherent.
- The FFE sequencer reads the active bank through a registered read port.

---
 rtl/ffe_pkg.sv | 11 +
 rtl/ffe_coeff_manager_if.sv | 44 ++++
 rtl/ffe_coeff_bank.sv | 24 ++
 rtl/ffe_coeff_manager.sv | 93 +++++++++
 tb/tb_ffe_coeff_manager.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/ffe_pkg.sv
// ffe_pkg: shared FSM encodings and default geometry for the FFE coefficient manager
package ffe_pkg;
  localparam int FFE_NUM_TAPS = 4;
  localparam int FFE_DEPTH = FFE_NUM_TAPS;
  localparam int FFE_COEFF_WIDTH = 8;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_PEND = 3'd2;
  localparam logic [2:0] ST_SWAP = 3'd3;
  localparam logic [2:0] ST_SYNC = 3'd4;
endpackage

// File: rtl/ffe_coeff_manager_if.sv
// ffe_coeff_manager_if: host config port, commit control and FFE read port of the coefficient manager
// slave = coefficient manager, master = host/FFE side.
// Readback signals exist only when FFE_COEFF_READBACK_EN is defined.
interface ffe_coeff_manager_if #(
  parameter int DEPTH = ffe_pkg::FFE_DEPTH,
  parameter int COEFF_WIDTH = ffe_pkg::FFE_COEFF_WIDTH,
  parameter int ADDR_SIZE = $clog2(DEPTH)
);
  logic cfg_valid;
  logic cfg_ready;
  logic [ADDR_SIZE-1:0] cfg_addr;
  logic [COEFF_WIDTH-1:0] cfg_data;
  logic commit;
  logic commit_done;
  logic busy;
  logic ffe_active;
  logic sym_boundary;
  logic rd_en;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [COEFF_WIDTH-1:0] rd_data;
  logic bank_sel;
`ifdef FFE_COEFF_READBACK_EN
  logic cfg_rd_en;
  logic [ADDR_SIZE-1:0] cfg_rd_addr;
  logic cfg_rd_bank;
  logic [COEFF_WIDTH-1:0] cfg_rd_data;
`endif
  modport slave (
`ifdef FFE_COEFF_READBACK_EN
    input cfg_rd_en, cfg_rd_addr, cfg_rd_bank,
    output cfg_rd_data,
`endif
    input cfg_valid, cfg_addr, cfg_data, commit, ffe_active, sym_boundary, rd_en, rd_addr,
    output cfg_ready, commit_done, busy, rd_data, bank_sel
  );
  modport master (
`ifdef FFE_COEFF_READBACK_EN
    output cfg_rd_en, cfg_rd_addr, cfg_rd_bank,
    input cfg_rd_data,
`endif
    output cfg_valid, cfg_addr, cfg_data, commit, ffe_active, sym_boundary, rd_en, rd_addr,
    input cfg_ready, commit_done, busy, rd_data, bank_sel
  );
endinterface

// File: rtl/ffe_coeff_bank.sv
// ffe_coeff_bank: DEPTH x COEFF_WIDTH register file, one sync write port, two combinational read ports
// Ports: ffe_clk, rst (async high, clears to zero), we/waddr/wdata write, ra0/rd0 and ra1/rd1 reads.
module ffe_coeff_bank #(
  parameter int DEPTH = ffe_pkg::FFE_DEPTH,
  parameter int COEFF_WIDTH = ffe_pkg::FFE_COEFF_WIDTH,
  parameter int ADDR_SIZE = $clog2(DEPTH)
) (
  input  logic ffe_clk,
  input  logic rst,
  input  logic we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [COEFF_WIDTH-1:0] wdata,
  input  logic [ADDR_SIZE-1:0] ra0,
  output logic [COEFF_WIDTH-1:0] rd0,
  input  logic [ADDR_SIZE-1:0] ra1,
  output logic [COEFF_WIDTH-1:0] rd1
);
  logic [COEFF_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge ffe_clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];
endmodule

// File: rtl/ffe_coeff_manager.sv
// ffe_coeff_manager: double-buffered FFE tap store; host loads the shadow bank, commit swaps at a symbol boundary
// Ports: ffe_clk, rst (async high), bus (ffe_coeff_manager_if.slave: cfg write handshake, commit/commit_done,
// busy, ffe_active/sym_boundary, registered FFE read port, bank_sel).
// FFE_COEFF_READBACK_EN adds a registered host readback of either bank; while SYNC owns the active bank's
// spare read port, an active-bank readback returns the tap currently being copied.
module ffe_coeff_manager import ffe_pkg::*; #(
  parameter int DEPTH = FFE_DEPTH,
  parameter int COEFF_WIDTH = FFE_COEFF_WIDTH,
  parameter int ADDR_SIZE = $clog2(DEPTH)
) (
  input logic ffe_clk,
  input logic rst,
  ffe_coeff_manager_if.slave bus
);
  localparam logic [ADDR_SIZE:0] LIMIT = (ADDR_SIZE + 1)'(DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(DEPTH - 1);
  logic [2:0] state, state_nx;
  logic [ADDR_SIZE-1:0] cnt, rb_addr;
  logic wr_acc, wr_ok, in_sync, sync_last;
  logic [COEFF_WIDTH-1:0] q0 [2];
  logic [COEFF_WIDTH-1:0] q1 [2];
  logic [COEFF_WIDTH-1:0] act0, act1;
  function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
    return {1'b0, a} < LIMIT;
  endfunction
  assign bus.cfg_ready = state == ST_IDLE || state == ST_LOAD;
  assign bus.busy = state == ST_PEND || state == ST_SWAP || state == ST_SYNC;
  assign wr_acc = bus.cfg_valid && bus.cfg_ready;
  assign wr_ok = wr_acc && in_range(bus.cfg_addr);
  assign in_sync = state == ST_SYNC;
  assign sync_last = in_sync && cnt == LAST;
`ifdef FFE_COEFF_READBACK_EN
  assign rb_addr = bus.cfg_rd_addr;
`else
  assign rb_addr = cnt;
`endif
  // Active bank: port0 serves the FFE, port1 serves the SYNC copy (else readback).
  // Shadow bank: port0 serves readback; it takes host writes and SYNC copies.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic act, we;
    logic [ADDR_SIZE-1:0] ra0, ra1;
    assign act = bus.bank_sel == 1'(b);
    assign we = !act && (wr_ok || in_sync);
    assign ra0 = act ? bus.rd_addr : rb_addr;
    assign ra1 = act && !in_sync ? rb_addr : cnt;
    ffe_coeff_bank #(.DEPTH(DEPTH), .COEFF_WIDTH(COEFF_WIDTH), .ADDR_SIZE(ADDR_SIZE)) u_bank (
      .ffe_clk(ffe_clk),
      .rst(rst),
      .we(we),
      .waddr(in_sync ? cnt : bus.cfg_addr),
      .wdata(in_sync ? act1 : bus.cfg_data),
      .ra0(ra0),
      .rd0(q0[b]),
      .ra1(ra1),
      .rd1(q1[b])
    );
  end
  assign act0 = bus.bank_sel ? q0[1] : q0[0];
  assign act1 = bus.bank_sel ? q1[1] : q1[0];
  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE: state_nx = wr_acc ? (bus.commit ? ST_PEND : ST_LOAD) : ST_IDLE;
      ST_LOAD: state_nx = bus.commit ? ST_PEND : ST_LOAD;
      ST_PEND: state_nx = bus.sym_boundary || !bus.ffe_active ? ST_SWAP : ST_PEND;
      ST_SWAP: state_nx = ST_SYNC;
      ST_SYNC: state_nx = sync_last ? ST_IDLE : ST_SYNC;
      default: state_nx = ST_IDLE;
    endcase
  end
  // bank_sel flips on the SWAP edge, so reads sampled in SWAP still see the old bank.
  always_ff @(posedge ffe_clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      bus.bank_sel <= 1'b0;
      bus.commit_done <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      state <= state_nx;
      cnt <= in_sync && !sync_last ? cnt + 1'b1 : '0;
      bus.bank_sel <= bus.bank_sel ^ (state == ST_SWAP);
      bus.commit_done <= sync_last || (state == ST_IDLE && bus.commit && !wr_acc);
      if (bus.rd_en) bus.rd_data <= in_range(bus.rd_addr) ? act0 : '0;
    end
`ifdef FFE_COEFF_READBACK_EN
  logic [COEFF_WIDTH-1:0] shd0;
  assign shd0 = bus.bank_sel ? q0[0] : q0[1];
  always_ff @(posedge ffe_clk or posedge rst)
    if (rst) bus.cfg_rd_data <= '0;
    else if (bus.cfg_rd_en) bus.cfg_rd_data <= !in_range(bus.cfg_rd_addr) ? '0 : bus.cfg_rd_bank ? shd0 : act1;
`endif
endmodule

// File: tb/tb_ffe_coeff_manager.sv
// tb_ffe_coeff_manager: directed self-checking bench for ffe_coeff_manager
module tb_ffe_coeff_manager;
  logic ffe_clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int pulses;
  logic [7:0] exp_taps [4];
  always #5 ffe_clk = ~ffe_clk;
  ffe_coeff_manager_if bus ();
  ffe_coeff_manager dut (.ffe_clk(ffe_clk), .rst(rst), .bus(bus));
  task automatic step(input int n);
    repeat (n) @(posedge ffe_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.cfg_valid = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    step(1);
    bus.cfg_valid = 1'b0;
  endtask
  initial begin
    bus.cfg_valid = 0; bus.cfg_addr = 0; bus.cfg_data = 0; bus.commit = 0;
    bus.ffe_active = 0; bus.sym_boundary = 0; bus.rd_en = 0; bus.rd_addr = 0;
`ifdef FFE_COEFF_READBACK_EN
    bus.cfg_rd_en = 0; bus.cfg_rd_addr = 0; bus.cfg_rd_bank = 0;
`endif
    step(2);
    rst = 1'b0;
    chk("reset cfg_ready", bus.cfg_ready, 1);
    chk("reset busy", bus.busy, 0);
    chk("reset bank_sel", bus.bank_sel, 0);
    chk("reset rd_data", bus.rd_data, 0);
    chk("reset commit_done", bus.commit_done, 0);
    // load 4 taps with FFE idle, commit swaps immediately
    wr(0, 8'h10); wr(1, 8'h20); wr(2, 8'h30); wr(3, 8'h40);
    chk("load cfg_ready", bus.cfg_ready, 1);
    bus.commit = 1; step(1); bus.commit = 0;
    chk("pend busy", bus.busy, 1);
    chk("pend cfg_ready", bus.cfg_ready, 0);
    step(4);
    chk("sync busy", bus.busy, 1);
    chk("done early +4", bus.commit_done, 0);
    step(1);
    chk("done early +5", bus.commit_done, 0);
    step(1);
    chk("done at +6", bus.commit_done, 1);
    chk("bank_sel after commit1", bus.bank_sel, 1);
    chk("idle after commit1", bus.busy, 0);
    bus.rd_en = 1; bus.rd_addr = 2; step(1); bus.rd_en = 0;
    chk("read addr2", bus.rd_data, 8'h30);
    chk("done pulse width", bus.commit_done, 0);
    // commit waits for sym_boundary while FFE busy
    bus.ffe_active = 1;
    wr(1, 8'h7F);
    bus.commit = 1; bus.rd_en = 1; bus.rd_addr = 1; step(1); bus.commit = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("pend read old", bus.rd_data, 8'h20);
      chk("pend bank_sel held", bus.bank_sel, 1);
      chk("pend busy held", bus.busy, 1);
    end
    bus.sym_boundary = 1; step(1); bus.sym_boundary = 0;
    chk("boundary read old", bus.rd_data, 8'h20);
    chk("boundary bank_sel", bus.bank_sel, 1);
    step(1);
    chk("swap read old", bus.rd_data, 8'h20);
    chk("swap bank_sel flip", bus.bank_sel, 0);
    step(1);
    chk("post swap read new", bus.rd_data, 8'h7F);
    bus.rd_en = 0;
    step(2);
    chk("done early b+4", bus.commit_done, 0);
    step(1);
    chk("done at b+5", bus.commit_done, 1);
    // write + commit in same cycle from IDLE, partial update keeps synced taps
    bus.ffe_active = 0;
    bus.cfg_valid = 1; bus.cfg_addr = 0; bus.cfg_data = 8'h01; bus.commit = 1;
    step(1);
    bus.cfg_valid = 0; bus.commit = 0;
    step(6);
    chk("done commit3", bus.commit_done, 1);
    chk("bank_sel commit3", bus.bank_sel, 1);
    exp_taps[0] = 8'h01; exp_taps[1] = 8'h7F; exp_taps[2] = 8'h30; exp_taps[3] = 8'h40;
    bus.rd_en = 1;
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = 2'(i);
      step(1);
      chk("synced tap", bus.rd_data, exp_taps[i]);
    end
    bus.rd_en = 0;
    // empty commit from IDLE: immediate pulse, no swap
    bus.commit = 1; step(1); bus.commit = 0;
    chk("empty commit done", bus.commit_done, 1);
    chk("empty commit busy", bus.busy, 0);
    chk("empty commit bank_sel", bus.bank_sel, 1);
    step(1);
    chk("empty commit pulse end", bus.commit_done, 0);
    // writes blocked while busy, second commit ignored
    bus.ffe_active = 1;
    wr(2, 8'h11);
    bus.commit = 1; step(1); bus.commit = 0;
    bus.cfg_valid = 1; bus.cfg_addr = 2; bus.cfg_data = 8'h99;
    chk("pend blocks write", bus.cfg_ready, 0);
    step(2);
    bus.commit = 1; step(1); bus.commit = 0;
    bus.sym_boundary = 1; step(1); bus.sym_boundary = 0;
    step(2);
    chk("sync blocks write", bus.cfg_ready, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (bus.commit_done) begin
        pulses++;
        bus.cfg_valid = 0;
      end
    end
    bus.cfg_valid = 0;
    chk("single commit_done", pulses, 1);
    chk("bank_sel commit5", bus.bank_sel, 0);
    bus.rd_en = 1; bus.rd_addr = 2; step(1);
    chk("held write dropped", bus.rd_data, 8'h11);
    bus.rd_addr = 3; step(1);
    chk("active addr3", bus.rd_data, 8'h40);
    bus.rd_en = 0;
    // shadow write without commit leaves the active bank alone
    bus.ffe_active = 0;
    wr(3, 8'h55);
`ifdef FFE_COEFF_READBACK_EN
    bus.cfg_rd_en = 1; bus.cfg_rd_bank = 1; bus.cfg_rd_addr = 3; step(1);
    chk("readback shadow", bus.cfg_rd_data, 8'h55);
    bus.cfg_rd_bank = 0; step(1);
    chk("readback active", bus.cfg_rd_data, 8'h40);
    bus.cfg_rd_en = 0;
`endif
    bus.rd_en = 1; bus.rd_addr = 3; step(1);
    chk("active unchanged addr3", bus.rd_data, 8'h40);
    // reset in the middle of SYNC
    bus.rd_addr = 0;
    wr(3, 8'h22);
    bus.commit = 1; step(1); bus.commit = 0;
    step(4);
    chk("mid sync busy", bus.busy, 1);
    chk("mid sync rd_data", bus.rd_data, 8'h01);
    rst = 1; #1;
    chk("async rst rd_data", bus.rd_data, 0);
    chk("async rst bank_sel", bus.bank_sel, 0);
    chk("async rst cfg_ready", bus.cfg_ready, 1);
    chk("async rst busy", bus.busy, 0);
    rst = 0;
    bus.rd_addr = 3; step(1);
    chk("post rst addr3", bus.rd_data, 0);
    bus.rd_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
